// File: rtl/line_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : line_scheduler
// Purpose  : Game sequencer for the row of line generators. Runs the
//            IDLE/RUN/PAUSE/OVER state machine, counts frames to time the
//            scrolls, issues each scroll as a one-hot sweep of shift enables,
//            gates the shared LFSR and tracks score and speed level.
// Ports    : clk_i, reset_i (sync, active-high)
//            start_i, pause_i, frame_i   - single-cycle control pulses
//            collision_i                 - level-sampled collision
//            shift_en_o [NUM_LINES]      - one-hot generator shift enables
//            lfsr_en_o                   - high while RUN
//            state_o [2]                 - 0 IDLE, 1 RUN, 2 PAUSE, 3 OVER
//            level_o [4], score_o [16]   - saturating level and score
//            game_over_o                 - high while OVER
// Revision : 1.0 - initial release
// ============================================================================
module line_scheduler #(
    parameter int NUM_LINES    = 4,
    parameter int BASE_PERIOD  = 30,
    parameter int PERIOD_STEP  = 2,
    parameter int MIN_PERIOD   = 4,
    parameter int LEVEL_SHIFTS = 16
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic                 pause_i,
    input  logic                 frame_i,
    input  logic                 collision_i,
    output logic [NUM_LINES-1:0] shift_en_o,
    output logic                 lfsr_en_o,
    output logic [1:0]           state_o,
    output logic [3:0]           level_o,
    output logic [15:0]          score_o,
    output logic                 game_over_o
);

    localparam int LVL_W = $clog2(LEVEL_SHIFTS + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [NUM_LINES-1:0] r_shift, w_shift_nxt;
    logic [7:0]           r_frame_cnt, w_cnt_nxt;
    logic                 r_sweep_pend, w_sp_nxt;
    logic                 r_pause_pend, w_pp_nxt;
    logic [LVL_W-1:0]     r_lvl_cnt, w_lvlcnt_nxt;
    logic [3:0]           r_level, w_level_nxt;
    logic [15:0]          r_score, w_score_nxt;
    logic                 r_lfsr_en, r_game_over;

    // Scroll period, computed signed so a large level cannot wrap below zero.
    logic [8:0]        w_dec;
    logic signed [8:0] w_period_raw;
    logic [7:0]        w_period;

    assign w_dec        = 9'(r_level) * 9'(PERIOD_STEP);
    assign w_period_raw = $signed(9'(BASE_PERIOD)) - $signed(w_dec);
    assign w_period     = (w_period_raw < $signed(9'(MIN_PERIOD))) ? 8'(MIN_PERIOD)
                                                                  : w_period_raw[7:0];

    logic w_active, w_last, w_req, w_pend;
    assign w_active = |r_shift;
    assign w_last   = r_shift[NUM_LINES-1];

    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_cnt_nxt    = r_frame_cnt;
        w_sp_nxt     = r_sweep_pend;
        w_pp_nxt     = r_pause_pend;
        w_lvlcnt_nxt = r_lvl_cnt;
        w_level_nxt  = r_level;
        w_score_nxt  = r_score;
        w_req        = 1'b0;
        w_pend       = 1'b0;

        case (r_state)
            S_IDLE, S_OVER: begin
                if (start_i) begin
                    w_state_nxt  = S_RUN;
                    w_shift_nxt  = '0;
                    w_cnt_nxt    = '0;
                    w_sp_nxt     = 1'b0;
                    w_pp_nxt     = 1'b0;
                    w_lvlcnt_nxt = '0;
                    w_level_nxt  = '0;
                    w_score_nxt  = '0;
                end
            end

            S_RUN: begin
                if (collision_i) begin
                    // Abort: no credit for a partial sweep, drop pending work.
                    w_state_nxt = S_OVER;
                    w_shift_nxt = '0;
                    w_sp_nxt    = 1'b0;
                    w_pp_nxt    = 1'b0;
                end else begin
                    // Pause outranks frame, so a frame coinciding with pause is lost.
                    if (frame_i && !pause_i) begin
                        if (r_frame_cnt >= w_period - 8'd1) begin
                            w_cnt_nxt = '0;
                            w_req     = 1'b1;
                        end else begin
                            w_cnt_nxt = r_frame_cnt + 8'd1;
                        end
                    end
                    // A request arriving while one is already pending is absorbed here.
                    w_pend = r_sweep_pend | w_req;

                    if (w_last) begin
                        if (r_score != 16'hFFFF) w_score_nxt = r_score + 16'd1;
                        if (r_lvl_cnt == LVL_W'(LEVEL_SHIFTS - 1)) begin
                            w_lvlcnt_nxt = '0;
                            if (r_level != 4'hF) w_level_nxt = r_level + 4'd1;
                        end else begin
                            w_lvlcnt_nxt = r_lvl_cnt + 1'b1;
                        end
                    end

                    if (!w_active) begin
                        if (pause_i) begin
                            w_state_nxt = S_PAUSE;
                        end else if (w_pend) begin
                            w_shift_nxt = NUM_LINES'(1);
                            w_sp_nxt    = 1'b0;
                        end
                    end else if (w_last) begin
                        if (r_pause_pend || pause_i) begin
                            w_state_nxt = S_PAUSE;
                            w_shift_nxt = '0;
                            w_pp_nxt    = 1'b0;
                            w_sp_nxt    = w_pend;
                        end else if (w_pend) begin
                            // Chain straight into the next sweep, no gap cycle.
                            w_shift_nxt = NUM_LINES'(1);
                            w_sp_nxt    = 1'b0;
                        end else begin
                            w_shift_nxt = '0;
                        end
                    end else begin
                        w_shift_nxt = {r_shift[NUM_LINES-2:0], 1'b0};
                        if (pause_i) w_pp_nxt = 1'b1;
                        w_sp_nxt = w_pend;
                    end
                end
            end

            S_PAUSE: begin
                if (pause_i) begin
                    w_state_nxt = S_RUN;
                    // A request held across the pause launches on resume.
                    if (r_sweep_pend) begin
                        w_shift_nxt = NUM_LINES'(1);
                        w_sp_nxt    = 1'b0;
                    end
                end
            end

            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state      <= S_IDLE;
            r_shift      <= '0;
            r_frame_cnt  <= '0;
            r_sweep_pend <= 1'b0;
            r_pause_pend <= 1'b0;
            r_lvl_cnt    <= '0;
            r_level      <= '0;
            r_score      <= '0;
            r_lfsr_en    <= 1'b0;
            r_game_over  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_shift      <= w_shift_nxt;
            r_frame_cnt  <= w_cnt_nxt;
            r_sweep_pend <= w_sp_nxt;
            r_pause_pend <= w_pp_nxt;
            r_lvl_cnt    <= w_lvlcnt_nxt;
            r_level      <= w_level_nxt;
            r_score      <= w_score_nxt;
            r_lfsr_en    <= (w_state_nxt == S_RUN);
            r_game_over  <= (w_state_nxt == S_OVER);
        end
    end

    assign shift_en_o  = r_shift;
    assign lfsr_en_o   = r_lfsr_en;
    assign state_o     = r_state;
    assign level_o     = r_level;
    assign score_o     = r_score;
    assign game_over_o = r_game_over;

endmodule
`default_nettype wire

// File: tb/tb_line_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_line_scheduler
// Purpose  : Directed self-checking bench for line_scheduler. Instance A uses
//            default parameters; instance B uses a one-frame period to
//            exercise chained sweeps and request dropping.
// Revision : 1.0 - initial release
// ============================================================================
module tb_line_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A (defaults)
    logic       a_rst = 1'b1, a_start = 1'b0, a_pause = 1'b0, a_frame = 1'b0, a_coll = 1'b0;
    logic [3:0] a_shift;
    logic       a_lfsr, a_go;
    logic [1:0] a_state;
    logic [3:0] a_level;
    logic [15:0] a_score;

    // Instance B (fast period)
    logic       b_rst = 1'b1, b_start = 1'b0, b_pause = 1'b0, b_frame = 1'b0, b_coll = 1'b0;
    logic [3:0] b_shift;
    logic       b_lfsr, b_go;
    logic [1:0] b_state;
    logic [3:0] b_level;
    logic [15:0] b_score;

    line_scheduler u_dut_a (
        .clk_i(clk), .reset_i(a_rst), .start_i(a_start), .pause_i(a_pause),
        .frame_i(a_frame), .collision_i(a_coll), .shift_en_o(a_shift),
        .lfsr_en_o(a_lfsr), .state_o(a_state), .level_o(a_level),
        .score_o(a_score), .game_over_o(a_go)
    );

    line_scheduler #(.NUM_LINES(4), .BASE_PERIOD(1), .PERIOD_STEP(2),
                     .MIN_PERIOD(1), .LEVEL_SHIFTS(16)) u_dut_b (
        .clk_i(clk), .reset_i(b_rst), .start_i(b_start), .pause_i(b_pause),
        .frame_i(b_frame), .collision_i(b_coll), .shift_en_o(b_shift),
        .lfsr_en_o(b_lfsr), .state_o(b_state), .level_o(b_level),
        .score_o(b_score), .game_over_o(b_go)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model of score bookkeeping for instance A
    int exp_score  = 0;
    int exp_lvlcnt = 0;
    int exp_level  = 0;

    function automatic int exp_period(input int lvl);
        int p;
        p = 30 - 2 * lvl;
        return (p < 4) ? 4 : p;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic frame_pulse_a;
        a_frame = 1'b1; tick; a_frame = 1'b0; tick;
    endtask

    // Full sweep on A: p-1 silent frames, terminal frame, 4 enable cycles.
    task automatic run_sweep(input int p);
        for (int i = 0; i < p - 1; i++) frame_pulse_a;
        n_vec++;
        if (a_shift !== 4'b0000) begin n_err++; $display("FAIL early_sweep p=%0d: shift=%b required 0000", p, a_shift); end
        a_frame = 1'b1; tick; a_frame = 1'b0;
        n_vec++;
        if (a_shift !== 4'b0001) begin n_err++; $display("FAIL sweep_start p=%0d: shift=%b required 0001", p, a_shift); end
        repeat (4) tick;
        exp_score++;
        exp_lvlcnt++;
        if (exp_lvlcnt == 16) begin
            exp_lvlcnt = 0;
            if (exp_level < 15) exp_level++;
        end
        n_vec++;
        if (a_shift !== 4'b0000 || a_score !== 16'(exp_score) || a_level !== 4'(exp_level)) begin
            n_err++;
            $display("FAIL sweep_end: shift=%b score=%0d level=%0d required 0000/%0d/%0d",
                     a_shift, a_score, a_level, exp_score, exp_level);
        end
    endtask

    task automatic test_reset;
        repeat (2) tick;
        a_rst = 1'b0; b_rst = 1'b0;
        n_vec++;
        if (a_shift !== 4'd0 || a_lfsr !== 1'b0 || a_state !== 2'd0 || a_level !== 4'd0 ||
            a_score !== 16'd0 || a_go !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: shift=%b lfsr=%b state=%0d level=%0d score=%0d go=%b required all 0",
                     a_shift, a_lfsr, a_state, a_level, a_score, a_go);
        end
        a_start = 1'b1; tick; a_start = 1'b0;
        n_vec++;
        if (a_state !== 2'd1 || a_lfsr !== 1'b1 || a_go !== 1'b0) begin
            n_err++; $display("FAIL start: state=%0d lfsr=%b go=%b required 1/1/0", a_state, a_lfsr, a_go);
        end
    endtask

    task automatic test_first_sweep;
        logic [3:0] exp_sh;
        for (int i = 0; i < 29; i++) frame_pulse_a;
        a_frame = 1'b1; tick; a_frame = 1'b0;
        exp_sh = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if (a_shift !== exp_sh) begin n_err++; $display("FAIL first_sweep[%0d]: shift=%b required %b", k, a_shift, exp_sh); end
            exp_sh = exp_sh << 1;
            tick;
        end
        n_vec++;
        if (a_shift !== 4'd0 || a_score !== 16'd1 || a_level !== 4'd0) begin
            n_err++; $display("FAIL first_sweep_end: shift=%b score=%0d level=%0d required 0000/1/0", a_shift, a_score, a_level);
        end
        exp_score = 1; exp_lvlcnt = 1; exp_level = 0;
    endtask

    task automatic test_levels;
        for (int s = 0; s < 15; s++) run_sweep(exp_period(exp_level));
        n_vec++;
        if (a_level !== 4'd1) begin n_err++; $display("FAIL level_one: level=%0d required 1", a_level); end
        run_sweep(28);      // period at level 1
        while (exp_level < 13) run_sweep(exp_period(exp_level));
        run_sweep(4);       // level 13 floor
        while (exp_level < 15) run_sweep(exp_period(exp_level));
        for (int s = 0; s < 16; s++) run_sweep(4);
        n_vec++;
        if (a_level !== 4'd15) begin n_err++; $display("FAIL level_sat: level=%0d required 15", a_level); end
    endtask

    task automatic test_collision;
        for (int i = 0; i < 3; i++) frame_pulse_a;
        a_frame = 1'b1; tick; a_frame = 1'b0;  // shift = 0001
        tick;                                   // shift = 0010
        tick;                                   // shift = 0100
        a_coll = 1'b1; tick; a_coll = 1'b0;
        n_vec++;
        if (a_shift !== 4'd0 || a_state !== 2'd3 || a_go !== 1'b1 || a_lfsr !== 1'b0 ||
            a_score !== 16'(exp_score)) begin
            n_err++;
            $display("FAIL collision: shift=%b state=%0d go=%b lfsr=%b score=%0d required 0000/3/1/0/%0d",
                     a_shift, a_state, a_go, a_lfsr, a_score, exp_score);
        end
        a_start = 1'b1; tick; a_start = 1'b0;
        n_vec++;
        if (a_state !== 2'd1 || a_score !== 16'd0 || a_level !== 4'd0 || a_go !== 1'b0) begin
            n_err++; $display("FAIL restart: state=%0d score=%0d level=%0d go=%b required 1/0/0/0",
                              a_state, a_score, a_level, a_go);
        end
        exp_score = 0; exp_lvlcnt = 0; exp_level = 0;
    endtask

    task automatic test_pause;
        logic seen;
        for (int i = 0; i < 29; i++) frame_pulse_a;
        a_frame = 1'b1; tick; a_frame = 1'b0;   // shift = 0001
        a_pause = 1'b1; tick; a_pause = 1'b0;   // shift = 0010
        tick; tick;                             // shift = 1000
        n_vec++;
        if (a_shift !== 4'b1000 || a_state !== 2'd1) begin
            n_err++; $display("FAIL pause_mid: shift=%b state=%0d required 1000/1", a_shift, a_state);
        end
        tick;
        n_vec++;
        if (a_shift !== 4'd0 || a_state !== 2'd2 || a_score !== 16'd1 || a_lfsr !== 1'b0) begin
            n_err++; $display("FAIL pause_enter: shift=%b state=%0d score=%0d lfsr=%b required 0000/2/1/0",
                              a_shift, a_state, a_score, a_lfsr);
        end
        exp_score = 1; exp_lvlcnt = 1;
        a_pause = 1'b1; tick; a_pause = 1'b0;
        for (int i = 0; i < 10; i++) frame_pulse_a;
        a_pause = 1'b1; tick; a_pause = 1'b0;
        n_vec++;
        if (a_state !== 2'd2) begin n_err++; $display("FAIL pause_idle: state=%0d required 2", a_state); end
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            frame_pulse_a;
            if (a_shift !== 4'd0) seen = 1'b1;
        end
        n_vec++;
        if (seen !== 1'b0 || a_state !== 2'd2) begin
            n_err++; $display("FAIL paused_frames: sweep_seen=%b state=%0d required 0/2", seen, a_state);
        end
        a_pause = 1'b1; tick; a_pause = 1'b0;
        n_vec++;
        if (a_state !== 2'd1) begin n_err++; $display("FAIL resume: state=%0d required 1", a_state); end
        run_sweep(20);      // counter resumes at 10 of 30
    endtask

    task automatic test_reset_mid_sweep;
        for (int s = 0; s < 3; s++) run_sweep(30);
        n_vec++;
        if (a_score !== 16'd5) begin n_err++; $display("FAIL score_five: score=%0d required 5", a_score); end
        for (int i = 0; i < 29; i++) frame_pulse_a;
        a_frame = 1'b1; tick; a_frame = 1'b0;
        tick;                                   // shift = 0010
        a_rst = 1'b1; tick; a_rst = 1'b0;
        n_vec++;
        if (a_shift !== 4'd0 || a_lfsr !== 1'b0 || a_state !== 2'd0 || a_level !== 4'd0 ||
            a_score !== 16'd0 || a_go !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid: shift=%b lfsr=%b state=%0d level=%0d score=%0d go=%b required all 0",
                     a_shift, a_lfsr, a_state, a_level, a_score, a_go);
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] exp_sh;
        b_start = 1'b1; tick; b_start = 1'b0;
        // Frames ahead of edges 1,3,...,11; each is terminal at period 1.
        for (int k = 1; k <= 17; k++) begin
            b_frame = ((k % 2) == 1) && (k <= 11);
            tick;
            b_frame = 1'b0;
            exp_sh = (k <= 16) ? (4'b0001 << ((k - 1) % 4)) : 4'b0000;
            n_vec++;
            if (b_shift !== exp_sh || b_score !== 16'((k - 1) / 4)) begin
                n_err++;
                $display("FAIL back_to_back[%0d]: shift=%b score=%0d required %b/%0d",
                         k, b_shift, b_score, exp_sh, (k - 1) / 4);
            end
        end
    endtask

    initial begin
        test_reset;
        test_first_sweep;
        test_levels;
        test_collision;
        test_pause;
        test_reset_mid_sweep;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/line_scheduler.md
# line_scheduler

Sequencing controller for the row of `line_generate` instances that feed the playfield. It runs the game state machine (idle, run, pause, game over) and counts display frames to decide when the lines scroll. Each scroll is issued as a staggered one-hot sweep of shift enables across the generators. It also gates the shared LFSR enable and tracks score and speed level.

## Interface
- `NUM_LINES`, 4: number of line generators sequenced, 2..8
- `BASE_PERIOD`, 30: frames between sweeps at level 0, 8-bit
- `PERIOD_STEP`, 2: period reduction per level
- `MIN_PERIOD`, 4: floor on the period, at least 1
- `LEVEL_SHIFTS`, 16: completed sweeps per level increment
- `clk_i` in 1: system clock; one clock domain.
- `reset_i` in 1: synchronous, active-high reset.
- `start_i` in 1: start/restart pulse
- `pause_i` in 1: pause toggle pulse
- `frame_i` in 1: one-cycle pulse per frame (vertical blank)
- `collision_i` in 1: player/line collision, level-sampled
- `shift_en_o` out NUM_LINES: one-hot per-generator shift enable
- `lfsr_en_o` out 1: enable for the generators' LFSRs
- `state_o` out 2: IDLE=0, RUN=1, PAUSE=2, OVER=3
- `level_o` out 4: speed level, saturates at 15
- `score_o` out 16: completed sweeps, saturates at 16'hFFFF
- `game_over_o` out 1: high while the state is OVER

## Operation
- **Reset:** all outputs are 0 and `state_o` is IDLE. Internal frame counter, sweep-pending flag, pause-pending flag and level sweep counter are 0.
- **IDLE or OVER:** `start_i` clears score, level, frame counter, level sweep counter and the pending flags, then moves to RUN. All other inputs are ignored.
- **Period:** `period = max(MIN_PERIOD, BASE_PERIOD - level*PERIOD_STEP)`.
  - Compute in 9-bit signed so the subtraction cannot wrap.
  - Defaults: level 0 gives 30, level 13 and above give 4.
- **Frame counting (RUN):** each `frame_i` increments the frame counter.
  - When `frame_i` arrives with the counter at period-1, the counter goes to 0 and a sweep is requested.
- **Sweep:**
  - `shift_en_o` becomes 1 (bit 0), then shifts left one bit per cycle.
  - After bit NUM_LINES-1 it returns to 0.
  - On that same edge, score increments (saturating) and the level sweep counter increments.
  - When the level sweep counter reaches LEVEL_SHIFTS, it clears and the level increments (saturating at 15).
- **Request during an active sweep:** set the pending flag. The next sweep starts on the cycle right after the current one ends, with no gap cycle. A second request while a request is already pending is dropped.
- **`pause_i` in RUN:** with no sweep active, go to PAUSE on the next edge. With a sweep active, latch pause-pending and enter PAUSE on the edge that ends the sweep. A pending sweep request is kept for after resume.
- **`pause_i` in PAUSE:** go to RUN. `frame_i` is ignored in PAUSE and the counter holds.
- **`collision_i` in RUN:**
  - Go to OVER on the next edge.
  - Any active sweep is aborted and `shift_en_o` is 0 from that edge.
  - No score increment for the aborted sweep.
  - Pending flags clear.
- **`collision_i` in PAUSE or IDLE:** ignored.
- **Priority within one cycle:** reset > collision > pause > frame. Collision and terminal `frame_i` in the same cycle: OVER, no sweep.
- **`lfsr_en_o`:** 1 exactly when the state is RUN.

## Timing
- All outputs are registered.
- First shift-enable latency: `shift_en_o[0]` is high in the cycle after the edge that samples a terminal `frame_i`.
- A sweep lasts NUM_LINES consecutive cycles.
- Score and level update on the edge where `shift_en_o` returns to 0, so they are visible one cycle after bit NUM_LINES-1.
- State changes take effect on the edge that samples the causing input; `state_o` and `game_over_o` follow in the same cycle.
- `reset_i` asserted mid-sweep: the next edge forces `shift_en_o` to 0, state to IDLE, and score and level to 0.

## Test plan
- Reset, then `start_i`, then 30 `frame_i` pulses. Expect `shift_en_o` = 1, 2, 4, 8 on the 4 cycles after the 30th pulse, then 0. `score_o` becomes 1 and `level_o` stays 0.
- Run 16 sweeps. Expect `level_o` = 1 and the next sweep after 28 frames. Force level 13+: the period is 4. Continue to level 15: it holds at 15.
- Assert `collision_i` in the cycle after `shift_en_o` = 2. Expect `shift_en_o` = 0 next cycle, `state_o` = 3, `game_over_o` = 1, `lfsr_en_o` = 0 and the score unchanged. Then `start_i`: state 1 with score 0.
- Pulse `pause_i` mid-sweep. Expect the sweep to complete, then state 2. Send 50 `frame_i` pulses: no sweep. Pulse `pause_i` again: state 1 and the frame count resumes where it stopped.
- Use `BASE_PERIOD` = 1, `NUM_LINES` = 4 with `frame_i` every 2 cycles. Expect back-to-back sweeps with no idle cycle between them and dropped extra requests. Score increments once per 4 cycles.
- Assert `reset_i` mid-sweep while in RUN at score 5. Next cycle: all outputs 0 and state IDLE.
